// File: rtl/data_ram.sv
// ---------------------------------------------------------------------------
// data_ram
//   Zero-wait-state data memory for the CPU load/store port.
//   - Loads return the addressed word combinationally in the access cycle.
//   - Stores are byte-lane masked and go through a 1-entry posted-write
//     buffer. The buffer commits to the array one edge later. Loads forward
//     from the buffer lane by lane, so a store is visible on the next cycle.
//   - After reset a clear engine zeroes one word per cycle. CPU accesses are
//     ignored until the sweep finishes: stores are dropped and loads return 0.
//
// Optional feature (macro): DATA_RAM_BOUNDS_CHECK_EN
//   Defined: an access with any of addr[31:ADDR_W+2] set is out of range.
//            The store is dropped, the load returns 0, and err_o sets. err_o
//            stays set until reset.
//   Undefined: upper address bits are ignored (aliasing) and err_o is tied 0.
//
// Ports
//   clk        in   1   clock, rising edge
//   reset_n    in   1   synchronous active-low reset
//   ce         in   1   access enable
//   we         in   1   1 = store, 0 = load
//   sel        in   4   byte lanes (sel[3] -> data[31:24])
//   addr       in   32  byte address, word index = addr[ADDR_W+1:2]
//   data_i     in   32  store data, lane aligned
//   data_o     out  32  load data (combinational, 0 unless a valid load)
//   init_done  out  1   high once the clear sweep has completed
//   err_o      out  1   sticky out-of-range flag
// ---------------------------------------------------------------------------
module data_ram #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        init_done,
  output logic        err_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;

  logic                r_wbuf_v;
  logic [ADDR_W-1:0]   r_wbuf_idx;
  logic [3:0]          r_wbuf_sel;
  logic [31:0]         r_wbuf_data;

  logic [31:0]         r_mem [DEPTH];

  logic [ADDR_W-1:0]   w_idx;
  logic                w_ready;
  logic                w_in_range;
  logic                w_store;
  logic                w_load;
  logic [31:0]         w_rd;
  logic                w_unused_addr;

  assign w_idx   = addr[ADDR_W+1:2];
  assign w_ready = (r_state == READY);

  // Byte offset is never used; the upper bits are used only by the bounds check.
  assign w_unused_addr = ^{addr[1:0], addr[31:ADDR_W+2]};

`ifdef DATA_RAM_BOUNDS_CHECK_EN
  logic r_err;

  assign w_in_range = (addr[31:ADDR_W+2] == '0);
  assign err_o      = r_err;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (w_ready && ce && !w_in_range) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_in_range = 1'b1;
  assign err_o      = 1'b0;
`endif

  assign w_store = w_ready & ce &  we & w_in_range;
  assign w_load  = w_ready & ce & ~we & w_in_range;

  // Next-state logic: the sweep ends on the cycle that clears the last word.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:   if (&r_clr_cnt) w_state_nxt = READY;
      READY:   w_state_nxt = READY;
      default: w_state_nxt = CLEAR;
    endcase
  end

  // Control state: FSM, clear counter and buffer-valid flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
      r_wbuf_v  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      r_wbuf_v <= w_store;
    end
  end

  assign init_done = w_ready;

  // Posted-write buffer payload. Only the valid flag needs reset.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_wbuf_idx  <= w_idx;
      r_wbuf_sel  <= sel;
      r_wbuf_data <= data_i;
    end
  end

  // Array write port. It is shared by the clear sweep and the buffer commit.
  // The buffer is never valid during CLEAR, so the two cannot collide. A
  // commit on a reset edge is suppressed, which discards a pending store.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (r_state == CLEAR) begin
        r_mem[r_clr_cnt] <= '0;
      end else if (r_wbuf_v) begin
        for (int k = 0; k < 4; k++) begin
          if (r_wbuf_sel[k]) r_mem[r_wbuf_idx][8*k +: 8] <= r_wbuf_data[8*k +: 8];
        end
      end
    end
  end

  // Read path: forward from the buffer, lane by lane, over the array word.
  always_comb begin
    w_rd = r_mem[w_idx];
    if (r_wbuf_v && (r_wbuf_idx == w_idx)) begin
      for (int k = 0; k < 4; k++) begin
        if (r_wbuf_sel[k]) w_rd[8*k +: 8] = r_wbuf_data[8*k +: 8];
      end
    end
  end

  assign data_o = w_load ? w_rd : 32'h0;

endmodule

// File: tb/tb_data_ram.sv
module tb_data_ram;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic        clk;
  logic        reset_n;
  logic        ce;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        init_done;
  logic        err_o;

  data_ram #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .we        (we),
    .sel       (sel),
    .addr      (addr),
    .data_i    (data_i),
    .data_o    (data_o),
    .init_done (init_done),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

`ifdef DATA_RAM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  // Reference model. It holds the architectural word contents, so a store
  // is visible to every later cycle. It also tracks the clear sweep length
  // and the sticky error flag.
  logic [31:0] m_mem [DEPTH];
  int          m_cnt;
  bit          m_ready;
  bit          m_err;

  function automatic bit in_range(input logic [31:0] a);
    if (!BOUNDS) return 1'b1;
    return (a[31:AW+2] == '0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      m_cnt   = 0;
      m_ready = 1'b0;
      m_err   = 1'b0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == DEPTH) m_ready = 1'b1;
    end else if (ce) begin
      if (!in_range(addr)) begin
        m_err = 1'b1;
      end else if (we) begin
        for (int k = 0; k < 4; k++)
          if (sel[k]) m_mem[addr[AW+1:2]][8*k +: 8] = data_i[8*k +: 8];
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    logic [31:0] exp_d;
    if (chk_en) begin
      exp_d = (m_ready && ce && !we && in_range(addr)) ? m_mem[addr[AW+1:2]] : 32'h0;
      check("data_o", data_o, exp_d);
      check("init_done", {31'h0, init_done}, {31'h0, m_ready});
      check("err_o", {31'h0, err_o}, {31'h0, m_err});
    end
  end

  task automatic cyc(input logic c, input logic w, input logic [3:0] s,
                     input logic [31:0] a, input logic [31:0] d);
    ce = c; we = w; sel = s; addr = a; data_i = d;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic ld(input string name, input logic [31:0] a, input logic [31:0] exp);
    ce = 1'b1; we = 1'b0; sel = 4'hF; addr = a; data_i = 32'h0;
    @(negedge clk);
    check(name, data_o, exp);
    @(posedge clk); #1;
  endtask

  task automatic rnd_cyc(input bit allow_oor);
    logic [31:0] a;
    logic [25:0] up;
    up = (allow_oor && ($urandom_range(0, 7) == 0)) ? 26'($urandom) : 26'h0;
    a  = {up, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
    cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
  endtask

  initial begin
    reset_n = 1'b0;
    ce = 1'b0; we = 1'b0; sel = 4'h0; addr = 32'h0; data_i = 32'h0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Sweep: accesses are ignored, and init_done rises on the DEPTH-th edge.
    for (int i = 0; i < DEPTH - 1; i++) rnd_cyc(1'b0);
    check("init_low_before_sweep_end", {31'h0, init_done}, 32'h0);
    rnd_cyc(1'b0);
    check("init_high_after_sweep", {31'h0, init_done}, 32'h1);
    ld("cleared_word8", 32'h8, 32'h0);

    // Forwarded read, then a read from the array.
    cyc(1'b1, 1'b1, 4'hF, 32'h8, 32'h11223344);
    ld("fwd_full_word", 32'h8, 32'h11223344);
    idle(); idle();
    ld("array_full_word", 32'h8, 32'h11223344);

    // Partial-lane merges.
    cyc(1'b1, 1'b1, 4'b0100, 32'h8, 32'hAABBCCDD);
    ld("merge_lane2", 32'h8, 32'h11BB3344);
    cyc(1'b1, 1'b1, 4'b0001, 32'h8, 32'h000000EE);
    ld("merge_lane0", 32'h8, 32'h11BB33EE);

    // Back-to-back stores to one word: the older store commits first.
    cyc(1'b1, 1'b1, 4'hF, 32'hC, 32'h12345678);
    cyc(1'b1, 1'b1, 4'b0010, 32'hC, 32'h0000AB00);
    ld("b2b_same_word", 32'hC, 32'h1234AB78);

    // Store with ce=0 is ignored and drives data_o to 0.
    ce = 1'b0; we = 1'b1; sel = 4'hF; addr = 32'h8; data_i = 32'hFFFFFFFF;
    @(negedge clk);
    check("ce0_data_o", data_o, 32'h0);
    @(posedge clk); #1;
    idle();
    ld("after_ce0", 32'h8, 32'h11BB33EE);

    // Store above the array: either rejected or aliased to word 0.
    cyc(1'b1, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D);
    idle();
    check("oor_err", {31'h0, err_o}, BOUNDS ? 32'h1 : 32'h0);
    ld("oor_word0", 32'h0, BOUNDS ? 32'h0 : 32'hCAFEF00D);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) rnd_cyc(1'b1);

    // Reset with a store pending, then a second reset partway through the sweep.
    cyc(1'b1, 1'b1, 4'hF, 32'h8, 32'h5A5A5A5A);
    reset_n = 1'b0;
    idle();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) idle();
    reset_n = 1'b0;
    idle();
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) idle();
    check("init_after_restart", {31'h0, init_done}, 32'h1);
    check("err_cleared", {31'h0, err_o}, 32'h0);
    ld("word8_after_reset", 32'h8, 32'h0);
    for (int i = 0; i < 200; i++) rnd_cyc(1'b1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
